uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Byte-wide transmit buffer placed directly upstream of simpleuart.
- Accepts bytes from a producer over a valid/ready interface and stores them in a synchronous FIFO.
- Drives simpleuart's data-register write port (reg_dat_we / reg_dat_di), honouring reg_dat_wait, so software or a stream source can enqueue bursts without polling the UART.

Parameters:
- DEPTH, 16, FIFO entries. Power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width. Derived; do not override.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous FIFO clear
- in_valid  input  1  producer byte valid
- in_data  input  8  producer byte
- in_ready  output  1  FIFO can accept in_data this cycle
- uart_we  output  1  to simpleuart reg_dat_we
- uart_di  output  32  to simpleuart reg_dat_di; bits [31:8] always 0
- uart_wait  input  1  from simpleuart reg_dat_wait
- level  output  AW+1  current occupancy, 0..DEPTH
- empty  output  1  level == 0
- full  output  1  level == DEPTH

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: rd_ptr = wr_ptr = 0, level = 0, empty = 1, full = 0, in_ready = 0 during the rst cycle, uart_we = 0, uart_di = 0. The storage array is not reset.
- Push: occurs when in_valid && in_ready.
  - in_ready = !full && !flush && !rst.
  - Data is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Output:
  - uart_we = !empty.
  - uart_di = {24'h0, mem[rd_ptr]}; combinational from the head entry.
- Pop (transfer to UART): occurs on a cycle where uart_we && !uart_wait.
  - rd_ptr increments modulo DEPTH.
  - This matches simpleuart, which latches the byte on any cycle where write-enable is high and wait is low.
- Latency: a byte pushed into an empty FIFO at cycle N appears with uart_we = 1 at cycle N+1. No fall-through.
- Simultaneous push and pop: both take effect and level is unchanged.
  - When full, in_ready = 0 even if a pop occurs in the same cycle (no pass-through).
  - When empty, a pop cannot occur because uart_we = 0.
- Level arithmetic: level_next = level + push - pop, computed in AW+1 bits. Pointers wrap naturally at AW bits.
- flush: sets both pointers and level to 0 next cycle; any push or pop in that cycle is discarded.
  - A byte already accepted by the UART in the flush cycle is still transmitted by the UART; only the FIFO state is cleared.
- Reset asserted mid-burst: behaves identically to flush, and also clears the CRLF state (see below).
- uart_we is never deasserted while uart_wait is high and the FIFO is non-empty. The UART therefore always sees a stable write request until it is accepted.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN.
- Defined: the block expands LF to CRLF.
  - When the head byte is 8'h0A and cr_done = 0, uart_di = 8'h0D and an accept does not pop; it sets cr_done = 1.
  - The next accept sends 8'h0A, pops the entry and clears cr_done.
  - cr_done is cleared by rst and by flush.
  - level counts stored entries, not bytes sent on the wire.
- Undefined: bytes pass through unmodified. cr_done logic is absent.

Decomposition:
- Shared package/header uart_defs:
  - UART_CHAR_CR = 8'h0D
  - UART_CHAR_LF = 8'h0A
  - byte width constant UART_DW = 8
- Sub-module sync_byte_fifo (generic DEPTH x 8 synchronous FIFO):
  - Inputs: push, pop, flush.
  - Outputs: head data, level, full, empty.
- uart_tx_fifo wraps sync_byte_fifo with the UART handshake and the optional CRLF stage.

Test Plan:
- Reset then idle: hold rst 2 cycles.
  - Required: uart_we = 0, level = 0, empty = 1, in_ready = 0 during rst and 1 the cycle after.
- Push 8'h41, 8'h42, 8'h43 back-to-back with uart_wait = 0.
  - Required: uart_we rises 1 cycle after the first push.
  - Required: uart_di sequence 32'h41, 32'h42, 32'h43, one per cycle; level returns to 0.
- Fill with DEPTH = 16 bytes while uart_wait = 1.
  - Required: full = 1, in_ready = 0, a 17th in_valid is not accepted, uart_di holds the first byte stable.
  - Then release uart_wait: all 16 bytes emerge in order.
- Simultaneous push and pop at level 5.
  - Required: level stays 5.
  - Assert flush at level 5: next cycle level = 0, uart_we = 0, and a push in the flush cycle is dropped.
- Wrap-around: stream 40 bytes (values 0..39) with uart_wait toggling every 3 cycles.
  - Required: output order exactly 0..39 with no duplicates or losses.
- With UART_TX_FIFO_CRLF_EN: push 8'h61, 8'h0A.
  - Required: UART accepts 8'h61, 8'h0D, 8'h0A; level decrements only on the 8'h61 and 8'h0A accepts.
  - Assert rst between the CR and LF accepts: cr_done clears and the FIFO empties.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART character and width constants for the transmit path.
package uart_defs;
    localparam int          UART_DW      = 8;
    localparam logic [7:0]  UART_CHAR_CR = 8'h0D;
    localparam logic [7:0]  UART_CHAR_LF = 8'h0A;
endpackage

// File: rtl/sync_byte_fifo.sv
// Generic DEPTH x byte synchronous FIFO with occupancy count; flush and rst clear it.
// Latency: write visible at head one cycle after push (no fall-through).
// Backpressure: push ignored when full, pop ignored when empty.
module sync_byte_fifo
    import uart_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [UART_DW-1:0] wr_data,
    output logic [UART_DW-1:0] head,
    output logic [AW:0]        level,
    output logic               full,
    output logic               empty
);
    logic [UART_DW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is deliberately not reset; head is qualified by empty downstream.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding simpleuart's data-register port; optional LF->CRLF via UART_TX_FIFO_CRLF_EN.
// Latency: pushed byte drives uart_we one cycle later; held stable until !uart_wait.
// Backpressure: in_ready drops when full, flushing or in reset.
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        uart_we,
    output logic [31:0] uart_di,
    input  logic        uart_wait,
    output logic [AW:0] level,
    output logic        empty,
    output logic        full
);
    logic               push;
    logic               pop;
    logic               accept;
    logic [UART_DW-1:0] head;
    logic [UART_DW-1:0] tx_byte;

    assign in_ready = !full && !flush && !rst;
    assign push     = in_valid && in_ready;
    assign uart_we  = !empty;
    assign accept   = uart_we && !uart_wait;
    assign uart_di  = empty ? 32'h0 : {24'h0, tx_byte};

`ifdef UART_TX_FIFO_CRLF_EN
    logic cr_done;
    logic send_cr;

    // An LF head is sent twice on the wire: first as CR (entry kept), then as LF (popped).
    assign send_cr = (head == UART_CHAR_LF) && !cr_done;
    assign tx_byte = send_cr ? UART_CHAR_CR : head;
    assign pop     = accept && !send_cr;

    always_ff @(posedge clk) begin
        if (rst || flush)  cr_done <= 1'b0;
        else if (accept)   cr_done <= send_cr;
    end
`else
    assign tx_byte = head;
    assign pop     = accept;
`endif

    sync_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );
endmodule
